key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
- Consumes the 16-bit raw key bitmap from the 4x4 matrix keyboard scanner. Bit i is low when key i is pressed; bit i = row*4 + column.
- Synchronises and debounces each key, detects press and release edges, and encodes each edge as a 4-bit key code plus a press/release flag.
- Queues events in a small FIFO with a valid/ready handshake, for the display/control logic downstream.

Parameters:
- SAMPLE_DIV, 60000: clk_in cycles between debounce samples (5 ms at 12 MHz). Legal minimum is 20.
- DEBOUNCE_SAMPLES, 4: consecutive differing samples required to accept a change. Legal range 2..15.
- FIFO_DEPTH, 4: event queue depth. Must be a power of 2, at least 2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- key_raw  input  16  raw scanner bitmap, active-low (0 = pressed)
- key_ready  input  1  consumer accepts the head event
- key_valid  output  1  FIFO non-empty; head event presented
- key_code  output  4  head event key index 0..15
- key_press  output  1  head event type: 1 = press, 0 = release
- key_state  output  16  debounced key map, active-high (1 = pressed)
- overflow  output  1  one-cycle pulse when an event is dropped

Behaviour:
- Reset (async, active-high, any time including mid-scan):
  - sync flops = 16'hffff.
  - sample counter, all debounce counters, key_state = 0.
  - FSM to IDLE, FIFO empty.
  - key_valid = 0, key_code = 0, key_press = 0, overflow = 0.
- Synchroniser: two-flop sync on key_raw. Define pressed_s = ~sync2.
- Sample tick:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick is high for 1 clk when the counter equals SAMPLE_DIV-1.
- Per-key debounce (on tick only):
  - If pressed_s[i] == key_state[i]: cnt[i] = 0.
  - Otherwise cnt[i]++. When the incremented value equals DEBOUNCE_SAMPLES: toggle key_state[i], clear cnt[i], set change[i].
  - Counters are 4 bits wide. A glitch shorter than DEBOUNCE_SAMPLES ticks resets the count and produces no change.
- Event FSM:
  - IDLE: on any tick with change != 0, latch change into chg_mask and go to SCAN with idx = 0.
  - SCAN: each clk, if chg_mask[idx], push {key_state[idx], idx} to the FIFO; idx++. At idx = 15, return to IDLE after processing.
  - SCAN lasts exactly 16 clks. SAMPLE_DIV >= 20 guarantees it ends before the next tick.
  - Events from one tick are pushed in ascending key index order.
- FIFO:
  - Push is accepted when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow pulses for that cycle.
  - Pop occurs when key_valid && key_ready.
  - Outputs are registered from the head entry. key_valid rises the clk after the push into an empty FIFO.
  - key_code/key_press hold stable while key_valid && !key_ready.
  - Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop on an empty FIFO is impossible (no bypass).
- Latency: raw edge to key_state change is 2 sync clks plus DEBOUNCE_SAMPLES ticks. The event becomes visible 2 to 17 clks after the accepting tick, depending on key index.

Test Plan (bench uses SAMPLE_DIV=20, DEBOUNCE_SAMPLES=4, FIFO_DEPTH=4):
1. Reset pulse with key_raw=16'h0000 -> key_state=0, key_valid=0, overflow=0 throughout reset. After release, no events until 4 ticks have elapsed.
2. key_raw=16'hffdf held for 6 ticks -> key_state=16'h0020 and exactly one event {code=5, press=1}. Release to 16'hffff -> one event {code=5, press=0}, key_state=0.
3. key_raw bit 3 low for 2 ticks, then high -> no event, key_state stays 0, cnt[3] returns to 0.
4. key_raw=16'h7ffe applied in one cycle -> two events in order {0,1} then {15,1}, and key_valid stays high across both with key_ready=1.
5. key_ready=0, then toggle keys to generate 6 events -> FIFO holds the first 4, overflow pulses exactly twice. With key_ready=1, the 4 events drain in original order and key_valid then drops.
6. Assert rst_in during SCAN with key_valid=1 -> all outputs return to reset values immediately (async). After release, no stale events appear.

Source files
------------

// File: rtl/key_event_decoder.sv
// Key matrix event decoder: synchronises and debounces a 16-key active-low bitmap,
// then queues press/release events (ascending key order per sample) behind valid/ready.
module key_event_decoder #(
  parameter int unsigned SAMPLE_DIV       = 60000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] key_raw,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_press,
  output logic [15:0] key_state,
  output logic        overflow
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SCAN} fsm_t;

  logic [15:0]      sync1_q, sync2_q, pressed_s;
  logic [CW-1:0]    div_q;
  logic             tick;
  logic [15:0][3:0] cnt_q, cnt_d;
  logic [15:0]      state_q, state_d, change;

  fsm_t             fsm_q;
  logic [3:0]       idx_q;
  logic [15:0]      mask_q;
  logic             push;
  logic [4:0]       push_data;

  logic [4:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, rd_q, wr_d, rd_d;
  logic [PW:0]      fcnt_q, fcnt_d;
  logic             full, pop, wr_en, drop;
  logic [4:0]       head_d;
  logic             valid_q, press_q, overflow_q;
  logic [3:0]       code_q;

  assign pressed_s = ~sync2_q;
  assign tick      = (div_q == CW'(SAMPLE_DIV - 1));

  always_comb begin
    state_d = state_q;
    change  = '0;
    cnt_d   = cnt_q;
    if (tick) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (pressed_s[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] + 4'd1 == 4'(DEBOUNCE_SAMPLES)) begin
          cnt_d[i]   = '0;
          state_d[i] = ~state_q[i];
          change[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= '1;
      sync2_q <= '1;
      div_q   <= '0;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fsm_q  <= IDLE;
      idx_q  <= '0;
      mask_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (tick && change != '0) begin
          mask_q <= change;
          idx_q  <= '0;
          fsm_q  <= SCAN;
        end
        SCAN: begin
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15) fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign push      = (fsm_q == SCAN) && mask_q[idx_q];
  assign push_data = {state_q[idx_q], idx_q};

  assign full   = (fcnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop    = valid_q && key_ready;
  assign wr_en  = push && (!full || pop);
  assign drop   = push && !wr_en;
  assign rd_d   = pop   ? rd_q + 1'b1 : rd_q;
  assign wr_d   = wr_en ? wr_q + 1'b1 : wr_q;
  assign fcnt_d = fcnt_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};
  // Next head is the entry being written this cycle only when the write lands on it.
  assign head_d = (wr_en && (rd_d == wr_q)) ? push_data : mem_q[rd_d];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      press_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fcnt_q     <= fcnt_d;
      valid_q    <= (fcnt_d != '0);
      overflow_q <= drop;
      if (fcnt_d != '0) begin
        code_q  <= head_d[3:0];
        press_q <= head_d[4];
      end
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_press = press_q;
  assign key_state = state_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with SAMPLE_DIV=20, DEBOUNCE_SAMPLES=4, FIFO_DEPTH=4.
module tb_key_event_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] key_raw;
  logic        key_ready;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_press;
  logic [15:0] key_state;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] ev_q [$];
  int ev_rd = 0;
  int ovf_n = 0;
  int ovf_base;

  always #5 clk_in = ~clk_in;

  key_event_decoder #(
    .SAMPLE_DIV(20),
    .DEBOUNCE_SAMPLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .key_raw(key_raw),
    .key_ready(key_ready),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_press(key_press),
    .key_state(key_state),
    .overflow(overflow)
  );

  // Record every handshake and every overflow pulse, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (key_valid && key_ready) ev_q.push_back({key_press, key_code});
      if (overflow) ovf_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return int'(ev_q.size()) - ev_rd;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    cyc(n * 20);
  endtask

  task automatic wait_events(input string tag, input int n, input int limit);
    for (int i = 0; i < limit && pending() < n; i++) cyc(1);
    chk(tag, pending(), n);
  endtask

  task automatic expect_ev(input string tag, input logic press, input logic [3:0] code);
    if (pending() > 0) begin
      chk(tag, ev_q[ev_rd], {press, code});
      ev_rd++;
    end else begin
      chk({tag, "_missing"}, pending(), 1);
    end
  endtask

  initial begin
    // 1: reset with all keys pressed at the input
    rst_in    = 1'b1;
    key_raw   = 16'h0000;
    key_ready = 1'b1;
    cyc(1);
    chk("rst_state", key_state, 16'h0000);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    cyc(2);
    chk("rst_code", key_code, 4'd0);
    chk("rst_press", key_press, 1'b0);
    chk("rst_ovf2", overflow, 1'b0);
    rst_in   = 1'b0;
    ovf_base = ovf_n;
    cyc(75);
    chk("t1_early_state", key_state, 16'h0000);
    chk("t1_early_valid", key_valid, 1'b0);
    chk("t1_early_events", pending(), 0);
    wait_events("t1_press_count", 16, 200);
    chk("t1_state_all", key_state, 16'hffff);
    for (int k = 0; k < 16; k++) expect_ev($sformatf("t1_press_%0d", k), 1'b1, 4'(k));
    key_raw = 16'hffff;
    wait_events("t1_rel_count", 16, 200);
    chk("t1_state_none", key_state, 16'h0000);
    for (int k = 0; k < 16; k++) expect_ev($sformatf("t1_rel_%0d", k), 1'b0, 4'(k));
    chk("t1_ovf", ovf_n - ovf_base, 0);

    // 2: single key 5
    key_raw = 16'hffdf;
    ticks(6);
    chk("t2_state", key_state, 16'h0020);
    chk("t2_count", pending(), 1);
    expect_ev("t2_press", 1'b1, 4'd5);
    key_raw = 16'hffff;
    ticks(6);
    chk("t2_rel_count", pending(), 1);
    expect_ev("t2_rel", 1'b0, 4'd5);
    chk("t2_state_rel", key_state, 16'h0000);

    // 3: two 2-tick glitches on key 3 separated by a release; counts must not accumulate
    key_raw = 16'hfff7;
    cyc(40);
    key_raw = 16'hffff;
    cyc(20);
    key_raw = 16'hfff7;
    cyc(40);
    key_raw = 16'hffff;
    ticks(6);
    chk("t3_events", pending(), 0);
    chk("t3_state", key_state, 16'h0000);

    // 4: keys 0 and 15 together
    key_raw = 16'h7ffe;
    ticks(6);
    chk("t4_count", pending(), 2);
    chk("t4_state", key_state, 16'h8001);
    expect_ev("t4_first", 1'b1, 4'd0);
    expect_ev("t4_second", 1'b1, 4'd15);
    key_raw = 16'hffff;
    ticks(6);
    chk("t4_rel_count", pending(), 2);
    expect_ev("t4_rel_first", 1'b0, 4'd0);
    expect_ev("t4_rel_second", 1'b0, 4'd15);

    // 5: six presses into a stalled 4-deep queue
    key_ready = 1'b0;
    ovf_base  = ovf_n;
    key_raw   = 16'hff21;
    ticks(6);
    chk("t5_state", key_state, 16'h00de);
    chk("t5_no_pop", pending(), 0);
    chk("t5_ovf", ovf_n - ovf_base, 2);
    chk("t5_valid", key_valid, 1'b1);
    chk("t5_head_code", key_code, 4'd1);
    chk("t5_head_press", key_press, 1'b1);
    cyc(5);
    chk("t5_hold_code", key_code, 4'd1);
    key_ready = 1'b1;
    cyc(10);
    chk("t5_drain_count", pending(), 4);
    expect_ev("t5_d0", 1'b1, 4'd1);
    expect_ev("t5_d1", 1'b1, 4'd2);
    expect_ev("t5_d2", 1'b1, 4'd3);
    expect_ev("t5_d3", 1'b1, 4'd4);
    chk("t5_empty", key_valid, 1'b0);
    key_raw = 16'hffff;
    ticks(6);
    chk("t5_rel_count", pending(), 6);
    expect_ev("t5_r1", 1'b0, 4'd1);
    expect_ev("t5_r2", 1'b0, 4'd2);
    expect_ev("t5_r3", 1'b0, 4'd3);
    expect_ev("t5_r4", 1'b0, 4'd4);
    expect_ev("t5_r6", 1'b0, 4'd6);
    expect_ev("t5_r7", 1'b0, 4'd7);
    chk("t5_ovf_after", ovf_n - ovf_base, 2);
    chk("t5_state_rel", key_state, 16'h0000);

    // 6: asynchronous reset while a scan is in progress
    key_ready = 1'b0;
    key_raw   = 16'h7ffe;
    for (int i = 0; i < 150 && !key_valid; i++) @(negedge clk_in);
    chk("t6_valid_before", key_valid, 1'b1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t6_valid", key_valid, 1'b0);
    chk("t6_state", key_state, 16'h0000);
    chk("t6_code", key_code, 4'd0);
    chk("t6_press", key_press, 1'b0);
    chk("t6_ovf", overflow, 1'b0);
    key_raw = 16'hffff;
    cyc(2);
    rst_in    = 1'b0;
    key_ready = 1'b1;
    ticks(8);
    chk("t6_no_stale", pending(), 0);
    chk("t6_valid_after", key_valid, 1'b0);
    chk("t6_state_after", key_state, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
